obj_buf_arbiter: RTL and testbench
==================================

# obj_buf_arbiter

Round-robin write arbiter and allocation controller for the object buffer. Shares the buffer's single write port among NUM_REQ field-decode requesters and tracks row occupancy with a mirrored valid bitmap, so row indices are known at grant time and the buffer can never be overrun. Sequences a whole-buffer flush through the buffer's reset. Sits between the parser lanes and object_buffer.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ROWS, 64, object buffer depth; must equal the buffer's row count
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- req_valid  in  NUM_REQ  per-requester write request
- req_entry  in  NUM_REQ x TABLE_ENTRY  per-requester entry payload
- req_ready  out  NUM_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- alloc_valid  out  1  registered; pulses once per accepted write
- alloc_id  out  $clog2(NUM_REQ)  requester that won
- alloc_row  out  $clog2(ROWS)  row the entry lands in
- occupancy  out  $clog2(ROWS)+1  rows in use (mirror popcount)
- ob_valid_in  out  1  to buffer valid_in, registered
- ob_new_entry  out  TABLE_ENTRY  to buffer new_entry, registered
- ob_reset  out  1  to buffer reset; OR'd with reset
- ob_full  in  1  buffer full flag (overrun check only)
- flush_req  in  1  level request to empty the buffer
- flush_done  out  1  one-cycle pulse when flush completes
- overrun_err  out  1  sticky; set if ob_valid_in & ob_full

## Operation
- Mirror bitmap `used[ROWS]`; free row = lowest index with used=0, the same choice the buffer makes.
- Grant when state==RUN, occupancy<ROWS, flush_req=0, some req_valid. Winner = first valid requester at or after rr_ptr, scanning upward with wrap. On grant: req_ready[winner]=1 (combinational, depends on req_valid), used[free]<=1, rr_ptr<=winner+1 mod NUM_REQ.
- occupancy==ROWS: all req_ready=0; rr_ptr held.
- FSM: RUN -> DRAIN on flush_req (no grant that cycle). DRAIN -> CLEAR when no registered write is pending. CLEAR: ob_reset=1 for one cycle, used<=0 -> DONE. DONE: flush_done=1 -> RUN. flush_req sampled only in RUN.
- overrun_err never fires in correct operation; it clears only on reset.
- reset: state RUN, used=0, rr_ptr=0, all outputs 0, ob_reset=1. Reset mid-flush aborts the flush without a flush_done pulse.

## Timing
- Grant cycle t: ob_valid_in, ob_new_entry, alloc_* valid at t+1. Buffer row valid after edge t+2.
- occupancy reflects the grant at t+1.
- Back-to-back grants: one per cycle, with distinct ascending rows.
- ob_full lags the mirror by 2 cycles. It is ignored for gating.
- Flush latency from flush_req in RUN: at most 4 cycles to the flush_done pulse.

## Configuration
- OBJ_ARB_STATS_EN defined: adds `stat_grants[NUM_REQ]` (16-bit saturating, per requester) and `stat_full_stalls` (16-bit saturating, cycles with any req_valid while occupancy==ROWS). All counters are cleared by reset and by CLEAR.
- OBJ_ARB_STATS_EN undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Shared package: TABLE_ENTRY (existing), the arbiter state enum, and the OBJ_ARB_CNT_W=16 constant.
- One sub-module, `rr_pick`: combinational round-robin selector (req vector, ptr -> one-hot grant, index, any).
- The lowest-free priority encoder stays inline.

## Test plan
- Reset, then requester 2 alone valid -> grant at t, alloc_row=0, alloc_id=2 at t+1, occupancy=1.
- All 4 requesters valid continuously with rr_ptr=0 -> grant order 0,1,2,3,0, rows 0..4, one grant per cycle.
- 64 writes then requester 1 still valid -> req_ready stays 0, occupancy=64, overrun_err=0, stat_full_stalls increments.
- flush_req with occupancy=10 and a grant pending -> pending write completes, ob_reset pulses one cycle, flush_done within 4 cycles, occupancy=0, next alloc_row=0.
- flush_req and req_valid in the same cycle -> no grant. Reset asserted during DRAIN -> no flush_done, all outputs 0.

Source files
------------

// File: rtl/obj_buf_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// obj_buf_arbiter_pkg
// Shared types for the object-buffer write arbiter:
//   TABLE_ENTRY    - one object-buffer row payload
//   arb_state_t    - arbiter flush sequencing states
//   OBJ_ARB_CNT_W  - width of the optional statistics counters
//   sat_inc()      - saturating increment for those counters
// -----------------------------------------------------------------------------
package obj_buf_arbiter_pkg;

    typedef struct packed {
        logic [7:0]  obj_id;
        logic [7:0]  field_id;
        logic [15:0] value;
    } TABLE_ENTRY;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int OBJ_ARB_CNT_W = 16;

    function automatic logic [OBJ_ARB_CNT_W-1:0] sat_inc(input logic [OBJ_ARB_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/obj_buf_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// obj_buf_arbiter_rr_pick
// Combinational round-robin selector. Picks the first asserted request at or
// after ptr, scanning upward and wrapping.
//   req   in  N    request vector
//   ptr   in  IW   scan start index
//   grant out N    one-hot winner (zero if no request)
//   idx   out IW   winner index
//   any   out 1    some request asserted
// -----------------------------------------------------------------------------
module obj_buf_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obj_buf_arbiter.sv
// -----------------------------------------------------------------------------
// obj_buf_arbiter
// Round-robin write arbiter and row allocator for object_buffer. A mirror of
// the buffer's valid bitmap lets the row be known at grant time and prevents
// overrun. Flushes are sequenced RUN -> DRAIN -> CLEAR -> DONE.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_entry/req_ready  requester handshake (one-hot ready)
//   alloc_valid/alloc_id/alloc_row registered grant report
//   occupancy                  rows in use
//   ob_valid_in/ob_new_entry   registered write to the buffer
//   ob_reset                   buffer reset (reset OR flush clear)
//   ob_full                    buffer full flag, overrun check only
//   flush_req/flush_done       flush handshake
//   overrun_err                sticky overrun flag
//
// Optional feature macro OBJ_ARB_STATS_EN adds stat_grants[] and
// stat_full_stalls saturating counters.
// -----------------------------------------------------------------------------
module obj_buf_arbiter
    import obj_buf_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ROWS    = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  TABLE_ENTRY [NUM_REQ-1:0]     req_entry,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         alloc_valid,
    output logic [$clog2(NUM_REQ)-1:0]   alloc_id,
    output logic [$clog2(ROWS)-1:0]      alloc_row,
    output logic [$clog2(ROWS):0]        occupancy,
    output logic                         ob_valid_in,
    output TABLE_ENTRY                   ob_new_entry,
    output logic                         ob_reset,
    input  logic                         ob_full,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic                         overrun_err
`ifdef OBJ_ARB_STATS_EN
    ,
    output logic [OBJ_ARB_CNT_W-1:0]     stat_grants [NUM_REQ],
    output logic [OBJ_ARB_CNT_W-1:0]     stat_full_stalls
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int ROW_W = $clog2(ROWS);
    localparam int OCC_W = ROW_W + 1;

    arb_state_t        state_reg;
    logic [ROWS-1:0]   used_reg;
    logic [OCC_W-1:0]  occ_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic              wr_valid_reg;
    logic [IDX_W-1:0]  alloc_id_reg;
    logic [ROW_W-1:0]  alloc_row_reg;
    TABLE_ENTRY        entry_reg;
    logic              overrun_reg;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant_en;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic [ROW_W-1:0]   free_row;
    logic               free_found;

    obj_buf_arbiter_rr_pick #(.N(NUM_REQ), .IW(IDX_W)) rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Lowest free row: the same choice the buffer makes, so alloc_row matches
    // where the entry actually lands.
    always_comb begin
        free_row   = '0;
        free_found = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (!free_found && !used_reg[r]) begin
                free_row   = ROW_W'(r);
                free_found = 1'b1;
            end
        end
    end

    // Reset gates the grant so req_ready is quiet while reset is held.
    assign grant_en = !reset && (state_reg == ST_RUN) && (occ_reg < OCC_W'(ROWS))
                      && !flush_req && pick_any;
    assign req_ready   = grant_en ? pick_grant : '0;
    assign rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            used_reg      <= '0;
            occ_reg       <= '0;
            rr_ptr_reg    <= '0;
            wr_valid_reg  <= 1'b0;
            alloc_id_reg  <= '0;
            alloc_row_reg <= '0;
            entry_reg     <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            wr_valid_reg <= grant_en;
            if (grant_en) begin
                used_reg[free_row] <= 1'b1;
                occ_reg            <= occ_reg + OCC_W'(1);
                rr_ptr_reg         <= rr_ptr_next;
                alloc_id_reg       <= pick_idx;
                alloc_row_reg      <= free_row;
                entry_reg          <= req_entry[pick_idx];
            end
            if (wr_valid_reg && ob_full)
                overrun_reg <= 1'b1;
            case (state_reg)
                ST_RUN:   if (flush_req) state_reg <= ST_DRAIN;
                // Wait for the last registered write to reach the buffer
                // before resetting it.
                ST_DRAIN: if (!wr_valid_reg) state_reg <= ST_CLEAR;
                ST_CLEAR: begin
                    used_reg  <= '0;
                    occ_reg   <= '0;
                    state_reg <= ST_DONE;
                end
                default:  state_reg <= ST_RUN;
            endcase
        end
    end

    assign alloc_valid  = wr_valid_reg;
    assign alloc_id     = alloc_id_reg;
    assign alloc_row    = alloc_row_reg;
    assign occupancy    = occ_reg;
    assign ob_valid_in  = wr_valid_reg;
    assign ob_new_entry = entry_reg;
    assign ob_reset     = reset || (state_reg == ST_CLEAR);
    assign flush_done   = (state_reg == ST_DONE);
    assign overrun_err  = overrun_reg;

`ifdef OBJ_ARB_STATS_EN
    logic                     stall_cycle;
    logic [OBJ_ARB_CNT_W-1:0] stall_cnt_reg;

    assign stall_cycle = (|req_valid) && (occ_reg == OCC_W'(ROWS));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat_grants
            logic [OBJ_ARB_CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset || state_reg == ST_CLEAR)
                    cnt_reg <= '0;
                else if (grant_en && pick_idx == IDX_W'(gi))
                    cnt_reg <= sat_inc(cnt_reg);
            end
            assign stat_grants[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || state_reg == ST_CLEAR)
            stall_cnt_reg <= '0;
        else if (stall_cycle)
            stall_cnt_reg <= sat_inc(stall_cnt_reg);
    end
    assign stat_full_stalls = stall_cnt_reg;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_obj_buf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obj_buf_arbiter
// Directed, table-driven bench for obj_buf_arbiter (NUM_REQ=4, ROWS=64) plus
// hand-written flush, fill and reset-abort sequences. Statistics checks are
// included when OBJ_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_obj_buf_arbiter;
    import obj_buf_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ROWS    = 64;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    TABLE_ENTRY [NUM_REQ-1:0] req_entry;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     alloc_valid;
    logic [1:0]               alloc_id;
    logic [5:0]               alloc_row;
    logic [6:0]               occupancy;
    logic                     ob_valid_in;
    TABLE_ENTRY               ob_new_entry;
    logic                     ob_reset;
    logic                     ob_full;
    logic                     flush_req;
    logic                     flush_done;
    logic                     overrun_err;
`ifdef OBJ_ARB_STATS_EN
    logic [15:0]              stat_grants [NUM_REQ];
    logic [15:0]              stat_full_stalls;
`endif

    obj_buf_arbiter #(.NUM_REQ(NUM_REQ), .ROWS(ROWS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_entry    (req_entry),
        .req_ready    (req_ready),
        .alloc_valid  (alloc_valid),
        .alloc_id     (alloc_id),
        .alloc_row    (alloc_row),
        .occupancy    (occupancy),
        .ob_valid_in  (ob_valid_in),
        .ob_new_entry (ob_new_entry),
        .ob_reset     (ob_reset),
        .ob_full      (ob_full),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .overrun_err  (overrun_err)
`ifdef OBJ_ARB_STATS_EN
        ,
        .stat_grants      (stat_grants),
        .stat_full_stalls (stat_full_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic TABLE_ENTRY mk_entry(input int r, input int v);
        TABLE_ENTRY e;
        e.obj_id   = 8'(r);
        e.field_id = 8'(v);
        e.value    = 16'(16'hBE00 + r);
        return e;
    endfunction

    task automatic set_entries(input int v);
        for (int i = 0; i < NUM_REQ; i++)
            req_entry[i] = mk_entry(i, v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] ready;
        logic       av;
        logic [1:0] id;
        logic [5:0] row;
        logic [6:0] occ;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int done_at;
        int rst_pulses;
        logic [15:0] s0;

        // req, ready, alloc_valid, id, row, occupancy after the edge
        vecs[0]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 6'd0, 7'd1};
        vecs[1]  = '{4'b1000, 4'b1000, 1'b1, 2'd3, 6'd1, 7'd2};
        vecs[2]  = '{4'b1111, 4'b0001, 1'b1, 2'd0, 6'd2, 7'd3};
        vecs[3]  = '{4'b1111, 4'b0010, 1'b1, 2'd1, 6'd3, 7'd4};
        vecs[4]  = '{4'b1111, 4'b0100, 1'b1, 2'd2, 6'd4, 7'd5};
        vecs[5]  = '{4'b1111, 4'b1000, 1'b1, 2'd3, 6'd5, 7'd6};
        vecs[6]  = '{4'b1111, 4'b0001, 1'b1, 2'd0, 6'd6, 7'd7};
        vecs[7]  = '{4'b0001, 4'b0001, 1'b1, 2'd0, 6'd7, 7'd8};
        vecs[8]  = '{4'b1010, 4'b0010, 1'b1, 2'd1, 6'd8, 7'd9};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 6'd0, 7'd9};
        vecs[10] = '{4'b0011, 4'b0001, 1'b1, 2'd0, 6'd9, 7'd10};

        reset = 1'b1; req_valid = '0; ob_full = 1'b0; flush_req = 1'b0;
        set_entries(0);
        step(); step();
        check("reset_ob_reset", 32'(ob_reset), 32'd1);
        check("reset_alloc_valid", 32'(alloc_valid), 32'd0);
        reset = 1'b0;
        step();
        check("post_reset_occ", 32'(occupancy), 32'd0);
        check("post_reset_ob_reset", 32'(ob_reset), 32'd0);
        check("post_reset_ready", 32'(req_ready), 32'd0);
        check("post_reset_flush_done", 32'(flush_done), 32'd0);
        check("post_reset_overrun", 32'(overrun_err), 32'd0);

        // Table-driven arbitration vectors
        for (int v = 0; v < 11; v++) begin
            req_valid = vecs[v].req;
            set_entries(v);
            #1;
            check("vec_ready", 32'(req_ready), 32'(vecs[v].ready));
            step();
            check("vec_alloc_valid", 32'(alloc_valid), 32'(vecs[v].av));
            check("vec_ob_valid_in", 32'(ob_valid_in), 32'(vecs[v].av));
            if (vecs[v].av) begin
                check("vec_alloc_id", 32'(alloc_id), 32'(vecs[v].id));
                check("vec_alloc_row", 32'(alloc_row), 32'(vecs[v].row));
                check("vec_entry", 32'(ob_new_entry), 32'(mk_entry(int'(vecs[v].id), v)));
            end
            check("vec_occ", 32'(occupancy), 32'(vecs[v].occ));
            $display("vec %0d req=%b ready=%b av=%0d id=%0d row=%0d occ=%0d",
                     v, vecs[v].req, vecs[v].ready, alloc_valid, alloc_id, alloc_row, occupancy);
        end

        // Flush with a registered write still pending and a request in the same cycle
        check("flush_pending_write", 32'(ob_valid_in), 32'd1);
        flush_req = 1'b1;
        req_valid = 4'b0010;
        #1;
        check("flush_same_cycle_no_grant", 32'(req_ready), 32'd0);
        check("flush_ob_reset_idle", 32'(ob_reset), 32'd0);
        done_at = 0;
        rst_pulses = 0;
        for (int c = 1; c <= 4; c++) begin
            if (done_at == 0) begin
                step();
                flush_req = 1'b0;
                if (ob_reset) rst_pulses++;
                check("flush_no_grant", 32'(req_ready), 32'd0);
                if (flush_done) done_at = c;
            end
        end
        $display("flush done_at=%0d ob_reset_cycles=%0d occ=%0d", done_at, rst_pulses, occupancy);
        check("flush_done_seen", 32'(done_at != 0), 32'd1);
        check("flush_ob_reset_pulses", 32'(rst_pulses), 32'd1);
        check("flush_occ_zero", 32'(occupancy), 32'd0);
        step();
        check("flush_done_single", 32'(flush_done), 32'd0);
        check("post_flush_ready", 32'(req_ready), 32'b0010);
        step();
        check("post_flush_row", 32'(alloc_row), 32'd0);
        check("post_flush_id", 32'(alloc_id), 32'd1);
        check("post_flush_occ", 32'(occupancy), 32'd1);
        $display("post-flush grant id=%0d row=%0d occ=%0d", alloc_id, alloc_row, occupancy);

        // Fill all rows from a fresh reset
        reset = 1'b1; req_valid = '0;
        step(); step();
        reset = 1'b0;
        step();
        req_valid = 4'b1111;
        for (int k = 0; k < ROWS; k++) begin
            step();
            check("fill_row", 32'(alloc_row), 32'(k));
            check("fill_id", 32'(alloc_id), 32'(k % NUM_REQ));
            $display("fill %0d id=%0d row=%0d occ=%0d", k, alloc_id, alloc_row, occupancy);
        end
        check("full_occ", 32'(occupancy), 32'd64);
`ifdef OBJ_ARB_STATS_EN
        s0 = stat_full_stalls;
        check("stat_stall_start", 32'(s0), 32'd0);
        for (int i = 0; i < NUM_REQ; i++)
            check("stat_grants", 32'(stat_grants[i]), 32'd16);
`else
        s0 = '0;
`endif
        req_valid = 4'b0010;
        #1;
        check("full_ready", 32'(req_ready), 32'd0);
        step();
        ob_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("full_ready_hold", 32'(req_ready), 32'd0);
            check("full_no_write", 32'(ob_valid_in), 32'd0);
            check("full_overrun", 32'(overrun_err), 32'd0);
        end
        check("full_occ_hold", 32'(occupancy), 32'd64);
`ifdef OBJ_ARB_STATS_EN
        check("stat_full_stalls", 32'(stat_full_stalls), 32'(s0 + 16'd4));
`endif

        // Reset while in DRAIN aborts the flush
        ob_full = 1'b0;
        req_valid = '0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        reset = 1'b1;
        req_valid = 4'b1111;
        step();
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_alloc_valid", 32'(alloc_valid), 32'd0);
        check("abort_ob_valid_in", 32'(ob_valid_in), 32'd0);
        check("abort_entry", 32'(ob_new_entry), 32'd0);
        check("abort_alloc_row", 32'(alloc_row), 32'd0);
        check("abort_occ", 32'(occupancy), 32'd0);
        check("abort_flush_done", 32'(flush_done), 32'd0);
        check("abort_ob_reset", 32'(ob_reset), 32'd1);
        reset = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("abort_no_done", 32'(flush_done), 32'd0);
        end
        check("abort_occ_after", 32'(occupancy), 32'd0);
        $display("abort sequence occ=%0d flush_done=%0d", occupancy, flush_done);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
